// File: rtl/alu_stateful.sv
// Fully pipelined stateful ALU for one action-stage container: three stages, one action per cycle,
// an internal key-value RAM with atomic load-add-store, and read-after-write forwarding.
module alu_stateful #(
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int STAGE      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  action_valid,
    input  logic [DATA_WIDTH-1:0] operand_1_in,
    input  logic [DATA_WIDTH-1:0] operand_2_in,
    input  logic [DATA_WIDTH-1:0] operand_3_in,
    output logic [DATA_WIDTH-1:0] container_out,
    output logic                  container_out_valid
);

    typedef enum logic [2:0] {
        OP_PASS,
        OP_ADD,
        OP_SUB,
        OP_STORE,
        OP_LOAD,
        OP_LOADD
    } op_e;

    typedef struct packed {
        logic                  valid;
        op_e                   op;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
        logic [DATA_WIDTH-1:0] op3;
    } stage_t;

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_rd_q;

    stage_t s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic                  fwd_valid_q, fwd_valid_d;
    logic [ADDR_WIDTH-1:0] fwd_addr_q, fwd_addr_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  out_valid_q, out_valid_d;

    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_we;

    logic unused_bits;
    assign unused_bits = ^{action_in[ACTION_LEN-5:0], 1'(STAGE)};

    always_comb begin
        s1_d       = '0;
        s1_d.valid = action_valid;
        s1_d.addr  = operand_2_in[ADDR_WIDTH-1:0];
        s1_d.op1   = operand_1_in;
        s1_d.op2   = operand_2_in;
        s1_d.op3   = operand_3_in;
        case (action_in[ACTION_LEN-1 -: 4])
            4'b0001, 4'b1001: s1_d.op = OP_ADD;
            4'b0010, 4'b1010: s1_d.op = OP_SUB;
            4'b1000:          s1_d.op = OP_STORE;
            4'b1011:          s1_d.op = OP_LOAD;
            4'b0111:          s1_d.op = OP_LOADD;
            default:          s1_d.op = OP_PASS;
        endcase
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // The RAM read in S3 was taken on the same edge the previous action's write committed,
    // so only that one-cycle-older write can be missing from ram_rd_q.
    always_comb begin
        rd_data   = (fwd_valid_q && fwd_addr_q == s3_q.addr) ? fwd_data_q : ram_rd_q;
        result    = s3_q.op3;
        ram_wdata = s3_q.op1;
        ram_we    = 1'b0;
        case (s3_q.op)
            OP_ADD:   result = s3_q.op1 + s3_q.op2;
            OP_SUB:   result = s3_q.op1 - s3_q.op2;
            OP_STORE: ram_we = s3_q.valid;
            OP_LOAD:  result = rd_data;
            OP_LOADD: begin
                result    = rd_data + s3_q.op1;
                ram_wdata = rd_data + s3_q.op1;
                ram_we    = s3_q.valid;
            end
            default:  result = s3_q.op3;
        endcase
        fwd_valid_d = ram_we;
        fwd_addr_d  = s3_q.addr;
        fwd_data_d  = ram_wdata;
        out_valid_d = s3_q.valid;
        out_d       = s3_q.valid ? result : out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Power-up contents are zero; reset leaves the stored values alone but blocks in-flight writes.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    always_ff @(posedge clk) begin
        ram_rd_q <= mem[s2_q.addr];
        if (ram_we && !rst) mem[s3_q.addr] <= ram_wdata;
    end

    assign container_out       = out_q;
    assign container_out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_stateful.sv
// Self-checking bench for alu_stateful: directed scenarios on the default build plus a randomized
// stream on a narrow build, checked against a sequential (one action at a time) reference model.
module tb_alu_stateful;

    localparam int AL  = 25;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int SDW = 16;
    localparam int SAW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AL-1:0] action_in;
    logic          action_valid;
    logic [DW-1:0] op1, op2, op3;
    logic [DW-1:0] out;
    logic          out_valid;

    logic [AL-1:0]  s_action_in;
    logic           s_action_valid;
    logic [SDW-1:0] s_op1, s_op2, s_op3;
    logic [SDW-1:0] s_out;
    logic           s_out_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] got_val[$];
    int          got_cyc[$];

    logic [SDW-1:0] ref_mem [2**SAW];

    alu_stateful #(.ACTION_LEN(AL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STAGE(0)) dut (
        .clk(clk), .rst(rst), .action_in(action_in), .action_valid(action_valid),
        .operand_1_in(op1), .operand_2_in(op2), .operand_3_in(op3),
        .container_out(out), .container_out_valid(out_valid)
    );

    alu_stateful #(.ACTION_LEN(AL), .DATA_WIDTH(SDW), .ADDR_WIDTH(SAW), .STAGE(1)) dut_s (
        .clk(clk), .rst(rst), .action_in(s_action_in), .action_valid(s_action_valid),
        .operand_1_in(s_op1), .operand_2_in(s_op2), .operand_3_in(s_op3),
        .container_out(s_out), .container_out_valid(s_out_valid)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Sequential meaning of one action on the narrow build, executed in issue order.
    function automatic logic [SDW-1:0] ref_exec(input logic [3:0] op,
                                                input logic [SDW-1:0] a, b, c);
        logic [SAW-1:0] addr;
        logic [SDW-1:0] r;
        addr = b[SAW-1:0];
        r    = c;
        case (op)
            4'b0001, 4'b1001: r = a + b;
            4'b0010, 4'b1010: r = a - b;
            4'b1000: ref_mem[addr] = a;
            4'b1011: r = ref_mem[addr];
            4'b0111: begin
                ref_mem[addr] = ref_mem[addr] + a;
                r = ref_mem[addr];
            end
            default: r = c;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid !== 1'b0) begin
            got_val.push_back(out);
            got_cyc.push_back(cyc);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, b, c);
        action_in    = {op, 21'($urandom)};
        action_valid = 1'b1;
        op1 = a;
        op2 = b;
        op3 = c;
        step();
    endtask

    task automatic idle(input int n);
        action_valid = 1'b0;
        action_in    = {4'b0111, 21'($urandom)};
        op1 = $urandom;
        op2 = $urandom;
        op3 = $urandom;
        repeat (n) step();
    endtask

    task automatic clear_obs();
        got_val.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        action_in    = {4'b0001, 21'd0};
        action_valid = 1'b1;
        op1 = 32'd3;
        op2 = 32'd4;
        op3 = 32'd9;
        s_action_valid = 1'b1;
        repeat (3) step();
        n_tests++;
        if (out !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_out: got %h expected 0", out);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
        end
        n_tests++;
        if (s_out !== 16'd0 || s_out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_narrow: got out %h valid %b expected 0/0", s_out, s_out_valid);
        end
        rst = 1'b0;
        s_action_valid = 1'b0;
        clear_obs();
        idle(6);
        n_tests++;
        if (got_val.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_ignored: got %0d pulses expected 0", got_val.size());
        end
    endtask

    task automatic test_add_sub();
        int base;
        logic [31:0] ev[$];
        int ec[$];
        clear_obs();
        base = cyc + 1;
        issue(4'b0001, 32'd5, 32'd7, 32'h99);
        issue(4'b1010, 32'd0, 32'd1, 32'h77);
        idle(6);
        ev = '{32'd12, 32'hFFFF_FFFF};
        ec = '{base + 3, base + 4};
        n_tests++;
        if (got_val.size() != ev.size()) begin
            n_fail++;
            $display("[TB] FAIL add_sub_count: got %0d pulses expected %0d", got_val.size(), ev.size());
        end else begin
            for (int i = 0; i < ev.size(); i++) begin
                n_tests++;
                if (got_val[i] !== ev[i] || got_cyc[i] !== ec[i]) begin
                    n_fail++;
                    $display("[TB] FAIL add_sub[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                             i, got_val[i], got_cyc[i], ev[i], ec[i]);
                end
            end
        end
        n_tests++;
        if (out !== 32'hFFFF_FFFF || out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL hold_out: got %h valid %b expected ffffffff valid 0", out, out_valid);
        end
    endtask

    task automatic test_store_load();
        int base;
        logic [31:0] ev[$];
        int ec[$];
        clear_obs();
        base = cyc + 1;
        issue(4'b1000, 32'hDEAD, 32'd3, 32'h11);
        idle(3);
        issue(4'b1011, 32'h0, 32'd3, 32'h44);
        idle(6);
        ev = '{32'h11, 32'hDEAD};
        ec = '{base + 3, base + 7};
        n_tests++;
        if (got_val.size() != ev.size()) begin
            n_fail++;
            $display("[TB] FAIL store_load_count: got %0d pulses expected %0d", got_val.size(), ev.size());
        end else begin
            for (int i = 0; i < ev.size(); i++) begin
                n_tests++;
                if (got_val[i] !== ev[i] || got_cyc[i] !== ec[i]) begin
                    n_fail++;
                    $display("[TB] FAIL store_load[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                             i, got_val[i], got_cyc[i], ev[i], ec[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [31:0] ev[$];
        int ec[$];
        clear_obs();
        base = cyc + 1;
        for (int i = 0; i < 5; i++) issue(4'b0111, 32'd1, 32'd7, $urandom);
        idle(4);
        issue(4'b1011, 32'd0, 32'd7, 32'h0);
        idle(6);
        ev = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd5};
        ec = '{base + 3, base + 4, base + 5, base + 6, base + 7, base + 12};
        n_tests++;
        if (got_val.size() != ev.size()) begin
            n_fail++;
            $display("[TB] FAIL loadd_count: got %0d pulses expected %0d", got_val.size(), ev.size());
        end else begin
            for (int i = 0; i < ev.size(); i++) begin
                n_tests++;
                if (got_val[i] !== ev[i] || got_cyc[i] !== ec[i]) begin
                    n_fail++;
                    $display("[TB] FAIL loadd[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                             i, got_val[i], got_cyc[i], ev[i], ec[i]);
                end
            end
        end
    endtask

    task automatic test_forwarding();
        int base;
        logic [31:0] ev[$];
        int ec[$];
        clear_obs();
        base = cyc + 1;
        issue(4'b1000, 32'hA, 32'd2, 32'h22);
        issue(4'b1011, 32'h0, 32'd2, 32'h0);
        issue(4'b1011, 32'h0, 32'd2, 32'h0);
        issue(4'b1011, 32'h0, 32'd34, 32'h0);
        issue(4'b1000, 32'hC, 32'h1000_0022, 32'h33);
        issue(4'b1011, 32'h0, 32'd34, 32'h0);
        idle(6);
        ev = '{32'h22, 32'hA, 32'hA, 32'hA, 32'h33, 32'hC};
        ec = '{base + 3, base + 4, base + 5, base + 6, base + 7, base + 8};
        n_tests++;
        if (got_val.size() != ev.size()) begin
            n_fail++;
            $display("[TB] FAIL fwd_count: got %0d pulses expected %0d", got_val.size(), ev.size());
        end else begin
            for (int i = 0; i < ev.size(); i++) begin
                n_tests++;
                if (got_val[i] !== ev[i] || got_cyc[i] !== ec[i]) begin
                    n_fail++;
                    $display("[TB] FAIL fwd[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                             i, got_val[i], got_cyc[i], ev[i], ec[i]);
                end
            end
        end
    endtask

    task automatic test_reset_in_flight();
        int base;
        clear_obs();
        issue(4'b0111, 32'd4, 32'd9, 32'h0);
        action_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (out !== 32'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flight_reset_out: got %h valid %b expected 0 valid 0", out, out_valid);
        end
        idle(6);
        n_tests++;
        if (got_val.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL flight_dropped: got %0d pulses expected 0", got_val.size());
        end
        clear_obs();
        base = cyc + 1;
        issue(4'b1011, 32'd0, 32'd9, 32'h0);
        idle(6);
        n_tests++;
        if (got_val.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL flight_load_count: got %0d pulses expected 1", got_val.size());
        end else if (got_val[0] !== 32'd0 || got_cyc[0] !== base + 3) begin
            n_fail++;
            $display("[TB] FAIL flight_load: got %h at cycle %0d expected 0 at cycle %0d",
                     got_val[0], got_cyc[0], base + 3);
        end
    endtask

    task automatic test_unknown_op();
        int base;
        logic [31:0] ev[$];
        int ec[$];
        clear_obs();
        base = cyc + 1;
        issue(4'b0100, 32'h1234, 32'd2, 32'h55);
        issue(4'b0000, 32'h5678, 32'd2, 32'h66);
        issue(4'b1011, 32'h0, 32'd2, 32'h0);
        idle(6);
        ev = '{32'h55, 32'h66, 32'hC};
        ec = '{base + 3, base + 4, base + 5};
        n_tests++;
        if (got_val.size() != ev.size()) begin
            n_fail++;
            $display("[TB] FAIL unknown_count: got %0d pulses expected %0d", got_val.size(), ev.size());
        end else begin
            for (int i = 0; i < ev.size(); i++) begin
                n_tests++;
                if (got_val[i] !== ev[i] || got_cyc[i] !== ec[i]) begin
                    n_fail++;
                    $display("[TB] FAIL unknown[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                             i, got_val[i], got_cyc[i], ev[i], ec[i]);
                end
            end
        end
    endtask

    task automatic test_random_stream();
        logic [SDW-1:0] exp_q[$];
        int             exp_cyc_q[$];
        logic [3:0]     op;
        logic [SDW-1:0] ev;
        int             ec;
        int             issued = 0;
        int             drain  = 0;
        logic [3:0]     op_table [10];
        op_table = '{4'b0001, 4'b1001, 4'b0010, 4'b1010, 4'b1000,
                     4'b1000, 4'b1011, 4'b0111, 4'b0111, 4'b0100};
        for (int i = 0; i < 2**SAW; i++) ref_mem[i] = '0;
        while (issued < 10000 || drain < 6) begin
            if (issued < 10000 && $urandom_range(0, 3) != 0) begin
                op = op_table[$urandom_range(0, 9)];
                if ($urandom_range(0, 15) == 0) op = 4'($urandom);
                s_action_in    = {op, 21'($urandom)};
                s_action_valid = 1'b1;
                s_op1 = 16'($urandom);
                s_op2 = 16'($urandom);
                s_op3 = 16'($urandom);
                exp_q.push_back(ref_exec(op, s_op1, s_op2, s_op3));
                exp_cyc_q.push_back(cyc + 1 + 3);
                issued++;
            end else begin
                s_action_valid = 1'b0;
                s_op1 = 16'($urandom);
                s_op2 = 16'($urandom);
                if (issued >= 10000) drain++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (s_out_valid !== 1'b0) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL rand_spurious: got %h at cycle %0d expected no pulse", s_out, cyc);
                end else begin
                    ev = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    if (s_out !== ev || cyc !== ec) begin
                        n_fail++;
                        $display("[TB] FAIL rand_result: got %h at cycle %0d expected %h at cycle %0d",
                                 s_out, cyc, ev, ec);
                    end
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL rand_missing: got %0d outstanding results expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst            = 1'b1;
        action_in      = '0;
        action_valid   = 1'b0;
        op1            = '0;
        op2            = '0;
        op3            = '0;
        s_action_in    = '0;
        s_action_valid = 1'b0;
        s_op1          = '0;
        s_op2          = '0;
        s_op3          = '0;
        test_reset();
        test_add_sub();
        test_store_load();
        test_back_to_back();
        test_forwarding();
        test_reset_in_flight();
        test_unknown_op();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
